// File: rtl/multi_correlation_tracker_if.sv
// Sample, threshold-adjust and readout signals of the multi-channel correlation tracker.
// The master drives samples and adjust pulses; the slave returns readout and per-channel flags.
interface multi_correlation_tracker_if #(
   parameter int NUM_CH = 6,
   parameter int W      = 10
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [W-1:0]      corr_in_i;
   logic [CH_W-1:0]   corr_chan_i;
   logic              corr_valid_i;
   logic [CH_W-1:0]   thresh_chan_i;
   logic              thresh_sel_i;
   logic              inc_thresh_i;
   logic              dec_thresh_i;
   logic [CH_W-1:0]   rd_chan_i;
   logic [W-1:0]      rd_filt_o;
   logic [W-1:0]      rd_thresh_high_o;
   logic [W-1:0]      rd_thresh_low_o;
   logic              rd_active_o;
   logic [NUM_CH-1:0] active_o;
   logic [NUM_CH-1:0] onset_o;
   logic [NUM_CH-1:0] release_o;

   modport master (
      output corr_in_i, corr_chan_i, corr_valid_i, thresh_chan_i, thresh_sel_i,
             inc_thresh_i, dec_thresh_i, rd_chan_i,
      input  rd_filt_o, rd_thresh_high_o, rd_thresh_low_o, rd_active_o,
             active_o, onset_o, release_o
   );

   modport slave (
      input  corr_in_i, corr_chan_i, corr_valid_i, thresh_chan_i, thresh_sel_i,
             inc_thresh_i, dec_thresh_i, rd_chan_i,
      output rd_filt_o, rd_thresh_high_o, rd_thresh_low_o, rd_active_o,
             active_o, onset_o, release_o
   );
endinterface

// File: rtl/multi_correlation_tracker.sv
// Time-multiplexed correlation tracker: per-channel IIR filter, hysteresis thresholds with a
// minimum hold time, runtime-adjustable thresholds and a registered readout port.
module multi_correlation_tracker #(
   parameter int NUM_CH           = 6,
   parameter int W                = 10,
   parameter int SHIFT            = 5,
   parameter int THRESH_HIGH_INIT = 1000,
   parameter int THRESH_LOW_INIT  = 750,
   parameter int STEP             = 4,
   parameter int HOLD_UPDATES     = 8,
   parameter int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   multi_correlation_tracker_if.slave   bus
);
   localparam int              HW      = $clog2(HOLD_UPDATES + 1);
   localparam logic [CH_W:0]   NCH     = NUM_CH[CH_W:0];
   localparam logic [W:0]      STEP_W1 = (W+1)'(STEP);
   localparam logic [W-1:0]    STEP_W  = W'(STEP);

   logic                         in_ok;
   logic                         s1_vld_q;
   logic [CH_W-1:0]              s1_chan_q;
   logic [NUM_CH-1:0][W-1:0]     filt_all, hi_all, lo_all;
   logic [NUM_CH-1:0]            act_vec, on_vec, rel_vec;
   logic [W-1:0]                 rd_filt_q, rd_hi_q, rd_lo_q;
   logic                         rd_act_q;

   assign in_ok = bus.corr_valid_i && ({1'b0, bus.corr_chan_i} < NCH);

   // Stage-1 tag: which channel's filter moved on the last edge, so stage 2 decides on it next.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_chan_q <= '0;
      end else begin
         s1_vld_q  <= in_ok;
         s1_chan_q <= bus.corr_chan_i;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [CH_W-1:0] GCH = CH_W'(g);

      logic [W-1:0]  filt_q, filt_d, hi_q, hi_d, lo_q, lo_d;
      logic [W:0]    hi_up, lo_up;
      logic [HW-1:0] hold_q, hold_d;
      logic          act_q, act_d, on_q, on_d, rel_q, rel_d;
      logic          upd1, upd2, adj;

      assign upd1  = in_ok && (bus.corr_chan_i == GCH);
      assign upd2  = s1_vld_q && (s1_chan_q == GCH);
      assign adj   = (bus.thresh_chan_i == GCH) && (bus.inc_thresh_i ^ bus.dec_thresh_i);
      assign hi_up = {1'b0, hi_q} + STEP_W1;
      assign lo_up = {1'b0, lo_q} + STEP_W1;

      always_comb begin
         // f - (f>>S) never underflows and the sum never exceeds 2^W-1, so W bits suffice.
         filt_d = upd1 ? (filt_q - (filt_q >> SHIFT) + (bus.corr_in_i >> SHIFT)) : filt_q;

         hold_d = hold_q;
         act_d  = act_q;
         on_d   = 1'b0;
         rel_d  = 1'b0;
         if (upd2) begin
            if (hold_q != '0) begin
               hold_d = hold_q - 1'b1;
            end else if (!act_q && (filt_q > hi_q)) begin
               act_d  = 1'b1;
               on_d   = 1'b1;
               hold_d = HW'(HOLD_UPDATES);
            end else if (act_q && (filt_q < lo_q)) begin
               act_d  = 1'b0;
               rel_d  = 1'b1;
               hold_d = HW'(HOLD_UPDATES);
            end
         end

         hi_d = hi_q;
         lo_d = lo_q;
         if (adj) begin
            if (bus.thresh_sel_i) begin
               if (bus.inc_thresh_i)
                  hi_d = hi_up[W] ? '1 : hi_up[W-1:0];
               else if ((hi_q >= STEP_W) && ((hi_q - STEP_W) >= lo_q))
                  hi_d = hi_q - STEP_W;
            end else begin
               if (bus.inc_thresh_i) begin
                  if (lo_up <= {1'b0, hi_q}) lo_d = lo_up[W-1:0];
               end else begin
                  lo_d = (lo_q < STEP_W) ? '0 : (lo_q - STEP_W);
               end
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            filt_q <= '0;
            hi_q   <= W'(THRESH_HIGH_INIT);
            lo_q   <= W'(THRESH_LOW_INIT);
            hold_q <= '0;
            act_q  <= 1'b0;
            on_q   <= 1'b0;
            rel_q  <= 1'b0;
         end else begin
            filt_q <= filt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            hold_q <= hold_d;
            act_q  <= act_d;
            on_q   <= on_d;
            rel_q  <= rel_d;
         end
      end

      assign filt_all[g] = filt_q;
      assign hi_all[g]   = hi_q;
      assign lo_all[g]   = lo_q;
      assign act_vec[g]  = act_q;
      assign on_vec[g]   = on_q;
      assign rel_vec[g]  = rel_q;
   end

   // Readout samples the state left by the previous edge.
   always_ff @(posedge clk) begin
      if (rst || ({1'b0, bus.rd_chan_i} >= NCH)) begin
         rd_filt_q <= '0;
         rd_hi_q   <= '0;
         rd_lo_q   <= '0;
         rd_act_q  <= 1'b0;
      end else begin
         rd_filt_q <= filt_all[bus.rd_chan_i];
         rd_hi_q   <= hi_all[bus.rd_chan_i];
         rd_lo_q   <= lo_all[bus.rd_chan_i];
         rd_act_q  <= act_vec[bus.rd_chan_i];
      end
   end

   assign bus.rd_filt_o        = rd_filt_q;
   assign bus.rd_thresh_high_o = rd_hi_q;
   assign bus.rd_thresh_low_o  = rd_lo_q;
   assign bus.rd_active_o      = rd_act_q;
   assign bus.active_o         = act_vec;
   assign bus.onset_o          = on_vec;
   assign bus.release_o        = rel_vec;
endmodule

// File: tb/tb_multi_correlation_tracker.sv
// Directed bench for multi_correlation_tracker: a cycle model pushes expected outputs each
// cycle, and they are popped and checked after the edge, alongside fixed-value checks.
module tb_multi_correlation_tracker;
   localparam int NUM_CH = 6;
   localparam int W      = 10;

   typedef struct {
      int filt, hi, lo, ract, act, on, rel;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multi_correlation_tracker_if #(.NUM_CH(NUM_CH), .W(W)) bus ();
   multi_correlation_tracker #(.NUM_CH(NUM_CH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   exp_t sb[$];
   int n_chk = 0, n_fail = 0;
   int m_filt[NUM_CH], m_hi[NUM_CH], m_lo[NUM_CH], m_act[NUM_CH], m_hold[NUM_CH];
   int m_s1v = 0, m_s1c = 0;
   int m_rf = 0, m_rh = 0, m_rl = 0, m_ra = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Behavioural model of one clock edge, using the inputs currently applied.
   task automatic model_edge();
      exp_t e;
      int c, rc, on, rel;
      on = 0; rel = 0;
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_filt[i] = 0; m_hi[i] = 1000; m_lo[i] = 750; m_act[i] = 0; m_hold[i] = 0;
         end
         m_s1v = 0; m_s1c = 0; m_rf = 0; m_rh = 0; m_rl = 0; m_ra = 0;
      end else begin
         rc = int'(bus.rd_chan_i);
         if (rc < NUM_CH) begin
            m_rf = m_filt[rc]; m_rh = m_hi[rc]; m_rl = m_lo[rc]; m_ra = m_act[rc];
         end else begin
            m_rf = 0; m_rh = 0; m_rl = 0; m_ra = 0;
         end
         if (m_s1v != 0) begin
            c = m_s1c;
            if (m_hold[c] != 0) m_hold[c]--;
            else if (m_act[c] == 0 && m_filt[c] > m_hi[c]) begin
               m_act[c] = 1; on = 1 << c; m_hold[c] = 8;
            end else if (m_act[c] == 1 && m_filt[c] < m_lo[c]) begin
               m_act[c] = 0; rel = 1 << c; m_hold[c] = 8;
            end
         end
         c = int'(bus.thresh_chan_i);
         if (c < NUM_CH && bus.inc_thresh_i != bus.dec_thresh_i) begin
            if (bus.thresh_sel_i) begin
               if (bus.inc_thresh_i) m_hi[c] = (m_hi[c] + 4 > 1023) ? 1023 : m_hi[c] + 4;
               else if (m_hi[c] - 4 >= m_lo[c]) m_hi[c] = m_hi[c] - 4;
            end else begin
               if (bus.inc_thresh_i) begin
                  if (m_lo[c] + 4 <= m_hi[c]) m_lo[c] = m_lo[c] + 4;
               end else m_lo[c] = (m_lo[c] < 4) ? 0 : m_lo[c] - 4;
            end
         end
         c = int'(bus.corr_chan_i);
         m_s1v = (bus.corr_valid_i && c < NUM_CH) ? 1 : 0;
         m_s1c = c;
         if (m_s1v != 0) m_filt[c] = m_filt[c] - (m_filt[c] >> 5) + (int'(bus.corr_in_i) >> 5);
      end
      e.filt = m_rf; e.hi = m_rh; e.lo = m_rl; e.ract = m_ra;
      e.act = 0;
      for (int i = 0; i < NUM_CH; i++) e.act |= m_act[i] << i;
      e.on = on; e.rel = rel;
      sb.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      model_edge();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("rd_filt", bus.rd_filt_o, e.filt);
      chk("rd_thresh_high", bus.rd_thresh_high_o, e.hi);
      chk("rd_thresh_low", bus.rd_thresh_low_o, e.lo);
      chk("rd_active", bus.rd_active_o, e.ract);
      chk("active", bus.active_o, e.act);
      chk("onset", bus.onset_o, e.on);
      chk("release", bus.release_o, e.rel);
   endtask

   initial begin
      int k, n_on, n_rel, on_at, rel_at;
      bus.corr_in_i = '0; bus.corr_chan_i = '0; bus.corr_valid_i = 1'b0;
      bus.thresh_chan_i = '0; bus.thresh_sel_i = 1'b0;
      bus.inc_thresh_i = 1'b0; bus.dec_thresh_i = 1'b0; bus.rd_chan_i = 3'd1;

      // Reset
      rst = 1'b1;
      repeat (2) cycle();
      chk("reset_active", bus.active_o, 0);
      chk("reset_rd_high", bus.rd_thresh_high_o, 0);
      rst = 1'b0;
      cycle();
      chk("init_high", bus.rd_thresh_high_o, 1000);
      chk("init_low", bus.rd_thresh_low_o, 750);
      chk("init_filt", bus.rd_filt_o, 0);

      // Full-scale input settles the filter at 992, so ch2's high threshold is lowered to 960.
      bus.thresh_chan_i = 3'd2; bus.thresh_sel_i = 1'b1; bus.dec_thresh_i = 1'b1;
      repeat (10) cycle();
      bus.dec_thresh_i = 1'b0; bus.rd_chan_i = 3'd2;
      repeat (2) cycle();
      chk("ch2_high_lowered", bus.rd_thresh_high_o, 960);

      // Ramp ch2 until the sample just driven lifts the filter above 960
      bus.corr_chan_i = 3'd2; bus.corr_in_i = 10'd1023; bus.corr_valid_i = 1'b1;
      n_on = 0; n_rel = 0; on_at = 0; rel_at = 0; k = 0;
      do begin
         cycle();
         k++;
         if (bus.onset_o[2]) n_on++;
         if (k == 2) chk("ramp_1", bus.rd_filt_o, 31);
         if (k == 3) chk("ramp_2", bus.rd_filt_o, 62);
         if (k == 4) chk("ramp_3", bus.rd_filt_o, 92);
      end while (m_filt[2] <= 960 && k < 300);
      chk("ramp_no_early_onset", n_on, 0);

      // Zeros: the filter dips below 750 on the 8th update while hold is still running
      bus.corr_in_i = '0;
      for (int z = 1; z <= 20; z++) begin
         cycle();
         if (bus.onset_o[2]) begin n_on++; if (on_at == 0) on_at = z; end
         if (bus.release_o[2]) begin n_rel++; if (rel_at == 0) rel_at = z; end
         if (z == 9) begin
            chk("dip_filt", bus.rd_filt_o, 748);
            chk("dip_still_active", bus.rd_active_o, 1);
         end
      end
      chk("onset_count", n_on, 1);
      chk("onset_latency", on_at, 1);
      chk("release_count", n_rel, 1);
      chk("release_position", rel_at, 10);
      bus.corr_valid_i = 1'b0;
      cycle();

      // Threshold adjust on ch1
      bus.rd_chan_i = 3'd1; bus.thresh_chan_i = 3'd1; bus.thresh_sel_i = 1'b1;
      bus.inc_thresh_i = 1'b1;
      repeat (6) cycle();
      bus.inc_thresh_i = 1'b0;
      cycle();
      chk("high_saturated", bus.rd_thresh_high_o, 1023);
      bus.inc_thresh_i = 1'b1; bus.dec_thresh_i = 1'b1;
      cycle();
      bus.inc_thresh_i = 1'b0; bus.dec_thresh_i = 1'b0;
      cycle();
      chk("inc_dec_together", bus.rd_thresh_high_o, 1023);
      bus.thresh_sel_i = 1'b0; bus.inc_thresh_i = 1'b1;
      repeat (80) cycle();
      bus.inc_thresh_i = 1'b0;
      cycle();
      chk("low_blocked_by_high", bus.rd_thresh_low_o, 1022);
      bus.thresh_sel_i = 1'b1; bus.dec_thresh_i = 1'b1;
      cycle();
      bus.dec_thresh_i = 1'b0; bus.thresh_chan_i = 3'd7; bus.inc_thresh_i = 1'b1;
      cycle();
      bus.inc_thresh_i = 1'b0;
      cycle();
      chk("high_dec_blocked", bus.rd_thresh_high_o, 1023);

      // Interleaved samples including an out-of-range channel
      bus.corr_valid_i = 1'b1;
      bus.corr_chan_i = 3'd0; bus.corr_in_i = 10'd640;  cycle();
      bus.corr_chan_i = 3'd5; bus.corr_in_i = 10'd1000; cycle();
      bus.corr_chan_i = 3'd7; bus.corr_in_i = 10'd1023; cycle();
      bus.corr_chan_i = 3'd0; bus.corr_in_i = 10'd320;  cycle();
      bus.corr_valid_i = 1'b0;
      bus.rd_chan_i = 3'd0; repeat (2) cycle();
      chk("ch0_filt", bus.rd_filt_o, 30);
      bus.rd_chan_i = 3'd5; cycle();
      chk("ch5_filt", bus.rd_filt_o, 31);
      bus.rd_chan_i = 3'd7; cycle();
      chk("rd_invalid_high", bus.rd_thresh_high_o, 0);
      bus.rd_chan_i = 3'd3; cycle();
      chk("ch3_untouched", bus.rd_filt_o, 0);

      // Reset right after an above-threshold sample
      bus.rd_chan_i = 3'd2; bus.corr_chan_i = 3'd2; bus.corr_in_i = 10'd1023;
      bus.corr_valid_i = 1'b1; k = 0;
      do begin cycle(); k++; end while (m_filt[2] <= 960 && k < 300);
      bus.corr_valid_i = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      n_on = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (bus.onset_o != '0) n_on++;
      end
      chk("rst_no_onset", n_on, 0);
      chk("rst_high", bus.rd_thresh_high_o, 1000);
      chk("rst_filt", bus.rd_filt_o, 0);
      chk("rst_active", bus.active_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
